// File: rtl/anneal_sequencer.sv
// anneal_sequencer: per-iteration phase sequencer for an annealing engine (strobes, distance commands, exp reciprocals, bank toggling)
package anneal_pkg;
    typedef enum logic [1:0] {THR = 2'd0, OR1 = 2'd1, TWO = 2'd2} opt_command_t;
    typedef enum logic [2:0] {KN = 3'd0, KM, KP, LN, LP, LM} dist_sel_t;
    typedef enum logic [1:0] {DNOP = 2'd0, ZERO, MNS, PLS} dist_op_t;
    typedef struct packed {
        dist_sel_t sel;
        dist_op_t  op;
    } distance_command_t;
    localparam distance_command_t DIST_NOP = '{sel: KN, op: DNOP};
endpackage

module anneal_sequencer
    import anneal_pkg::*;
#(
    parameter int CNT_W      = 24,
    parameter int CYCLE_LEN  = 100,
    parameter int DIST_AT    = 20,
    parameter int EXP_AT0    = 40,
    parameter int METRO_AT   = 58,
    parameter int EXP_AT1    = 60,
    parameter int REPLICA_AT = 78,
    parameter int EXCH_AT    = 80,
    parameter int EXP_TERMS  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_write,
    input  logic [CNT_W-1:0]  run_times,
    input  logic [1:0]        mode_sel,
    input  logic              abort,
    input  logic              exchange_shift,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  iter_cnt,
    output opt_command_t      opt_command,
    output logic              random_run,
    output distance_command_t distance_com,
    output logic              metropolis_run,
    output logic              replica_run,
    output logic              exchange_run,
    output logic              exchange_bank,
    output logic              exp_init,
    output logic              exp_run,
    output logic [16:0]       exp_recip
);
    localparam int CC_W = $clog2(CYCLE_LEN + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CC_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0] run_times_q, iter_nxt;
    logic [1:0]       mode_q;
    logic [3:0]       exp_k;
    logic             accept, start, abort_run, wrap, wrap_go, last;

    assign accept    = state == IDLE && run_write && !abort;
    assign start     = accept && run_times != '0;
    assign abort_run = state == RUN && abort;
    assign wrap      = state == RUN && cycle_cnt == CC_W'(CYCLE_LEN);
    assign wrap_go   = wrap && !abort;
    assign iter_nxt  = iter_cnt + CNT_W'(1);
    assign last      = iter_nxt == run_times_q;

    function automatic distance_command_t dist_cmd(input opt_command_t opt, input logic [2:0] idx);
        distance_command_t c;
        c = DIST_NOP;
        if (opt == OR1)
            case (idx)
                3'd0:    c = '{KN, ZERO};
                3'd1:    c = '{KM, MNS};
                3'd2:    c = '{KP, PLS};
                3'd3:    c = '{KN, MNS};
                3'd4:    c = '{LN, PLS};
                3'd5:    c = '{LP, MNS};
                3'd6:    c = '{KN, PLS};
                default: c = DIST_NOP;
            endcase
        else if (opt == TWO)
            case (idx)
                3'd0:    c = '{KN, ZERO};
                3'd1:    c = '{KM, MNS};
                3'd2:    c = '{LM, PLS};
                3'd3:    c = '{LN, MNS};
                3'd4:    c = '{KN, PLS};
                default: c = DIST_NOP;
            endcase
        return c;
    endfunction

    // floor(32768/k) as a constant table so no divider is built
    function automatic logic [16:0] recip(input logic [3:0] k);
        case (k)
            4'd1:    return 17'd32768;
            4'd2:    return 17'd16384;
            4'd3:    return 17'd10922;
            4'd4:    return 17'd8192;
            4'd5:    return 17'd6553;
            4'd6:    return 17'd5461;
            4'd7:    return 17'd4681;
            4'd8:    return 17'd4096;
            4'd9:    return 17'd3640;
            4'd10:   return 17'd3276;
            4'd11:   return 17'd2978;
            4'd12:   return 17'd2730;
            4'd13:   return 17'd2520;
            4'd14:   return 17'd2340;
            4'd15:   return 17'd2184;
            default: return 17'd0;
        endcase
    endfunction

    // run/idle state register
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nxt;

    // enter RUN on a non-empty start, leave on abort or after the final iteration
    always_comb
        state_nxt = state == IDLE ? (start ? RUN : IDLE) : (abort || (wrap && last)) ? IDLE : RUN;

    // phase strobes decoded straight from the cycle counter (it sits at 0 while idle)
    always_comb begin
        running        = state == RUN;
        metropolis_run = cycle_cnt == CC_W'(METRO_AT);
        replica_run    = cycle_cnt == CC_W'(REPLICA_AT);
        exchange_run   = cycle_cnt == CC_W'(EXCH_AT);
        exp_init       = cycle_cnt == CC_W'(EXP_AT0) || cycle_cnt == CC_W'(EXP_AT1);
    end

    // iteration bookkeeping: cycle counter, iteration count, optimiser command, start/done pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            iter_cnt    <= '0;
            opt_command <= THR;
            random_run  <= 1'b0;
            done        <= 1'b0;
            run_times_q <= '0;
            mode_q      <= '0;
        end else begin
            done        <= (accept && run_times == '0) || (wrap_go && last);
            random_run  <= start || (wrap_go && !last);
            cycle_cnt   <= (state != RUN || abort || wrap) ? '0 :
                           (random_run || cycle_cnt != '0) ? cycle_cnt + CC_W'(1) : '0;
            iter_cnt    <= start ? '0 : wrap_go ? iter_nxt : iter_cnt;
            run_times_q <= accept ? run_times : run_times_q;
            mode_q      <= accept ? mode_sel : mode_q;
            opt_command <= start ? (mode_sel[1] ? TWO : OR1) :
                           (abort_run || (wrap_go && last)) ? THR :
                           (wrap_go && mode_q[1] == mode_q[0]) ? (opt_command == OR1 ? TWO : OR1) :
                           opt_command;
        end
    end

    // distance command for index i is registered one cycle early so it appears at DIST_AT+2+i
    always_ff @(posedge clk)
        distance_com <= (reset || state != RUN || abort ||
                         cycle_cnt < CC_W'(DIST_AT + 1) || cycle_cnt > CC_W'(DIST_AT + 7)) ? DIST_NOP :
                        dist_cmd(opt_command, 3'(cycle_cnt - CC_W'(DIST_AT + 1)));

    // exp window: count k down from EXP_TERMS to 1, presenting 32768/k each cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_run   <= 1'b0;
            exp_k     <= '0;
            exp_recip <= '0;
        end else if (abort_run) begin
            exp_run <= 1'b0;
        end else if (exp_init) begin
            exp_run   <= 1'b1;
            exp_k     <= 4'(EXP_TERMS);
            exp_recip <= recip(4'(EXP_TERMS));
        end else if (exp_run) begin
            exp_run <= exp_k != 4'd1;
            if (exp_k != 4'd1) begin
                exp_k     <= exp_k - 4'd1;
                exp_recip <= recip(exp_k - 4'd1);
            end
        end
    end

    // bank flips once per cycle on either toggle source, running or not
    always_ff @(posedge clk)
        exchange_bank <= reset ? 1'b0 : exchange_bank ^ (exchange_run | exchange_shift);
endmodule

// File: tb/tb_anneal_sequencer.sv
// tb_anneal_sequencer: scoreboard bench driving directed and random runs against a timeline model
module tb_anneal_sequencer;
    import anneal_pkg::*;

    localparam int CNT_W = 24;
    localparam int L     = 100;
    localparam int IT    = L + 1;
    localparam int K_RR = 0, K_DN = 1, K_MR = 2, K_RP = 3, K_EX = 4, K_EI = 5, K_ER = 6, K_DC = 7;

    logic              clk = 1'b0, reset = 1'b1, run_write = 1'b0, abort = 1'b0, exchange_shift = 1'b0;
    logic [CNT_W-1:0]  run_times = '0;
    logic [1:0]        mode_sel = '0;
    logic              running, done, random_run, metropolis_run, replica_run, exchange_run;
    logic              exchange_bank, exp_init, exp_run;
    logic [CNT_W-1:0]  iter_cnt;
    logic [16:0]       exp_recip;
    opt_command_t      opt_command;
    distance_command_t distance_com;

    anneal_sequencer dut (
        .clk(clk), .reset(reset), .run_write(run_write), .run_times(run_times), .mode_sel(mode_sel),
        .abort(abort), .exchange_shift(exchange_shift), .running(running), .done(done),
        .iter_cnt(iter_cnt), .opt_command(opt_command), .random_run(random_run),
        .distance_com(distance_com), .metropolis_run(metropolis_run), .replica_run(replica_run),
        .exchange_run(exchange_run), .exchange_bank(exchange_bank), .exp_init(exp_init),
        .exp_run(exp_run), .exp_recip(exp_recip)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          t;
        logic [31:0] data;
    } ev_t;

    ev_t q[$];
    bit  run_exp[int];
    bit  xrun[int];
    int  cyc = 0, checks = 0, errors = 0;
    bit  mon_en = 1'b0, model_bank = 1'b0;

    distance_command_t or1_seq [7] = '{'{KN, ZERO}, '{KM, MNS}, '{KP, PLS}, '{KN, MNS},
                                       '{LN, PLS}, '{LP, MNS}, '{KN, PLS}};
    distance_command_t two_seq [5] = '{'{KN, ZERO}, '{KM, MNS}, '{LM, PLS}, '{LN, MNS}, '{KN, PLS}};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_RR:    return "random_run";
            K_DN:    return "done";
            K_MR:    return "metropolis_run";
            K_RP:    return "replica_run";
            K_EX:    return "exchange_run";
            K_EI:    return "exp_init";
            K_ER:    return "exp_run";
            default: return "distance_com";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int t, input logic [31:0] data, input int limit);
        if (t <= limit) q.push_back('{kind, t, data});
    endtask

    task automatic see_ev(input int kind, input logic [31:0] data);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s at cyc %0d data %0h, required no event", kname(kind), cyc, data);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.t != cyc || e.data !== data) begin
                errors++;
                $display("FAIL event: got %s@%0d data %0h, required %s@%0d data %0h",
                         kname(kind), cyc, data, kname(e.kind), e.t, e.data);
            end
        end
    endtask

    // timeline of one run accepted at the edge after cycle c; nothing later than limit is expected
    task automatic push_run(input int c, input int r, input logic [1:0] m, input int limit);
        opt_command_t first, other, o;
        first = m[1] ? TWO : OR1;
        other = m[1] ? OR1 : TWO;
        for (int n = 0; n < r; n++) begin
            int b;
            b = c + 1 + n * IT;
            o = ((m == 2'b00 || m == 2'b11) && n % 2 == 1) ? other : first;
            expect_ev(K_RR, b, {30'b0, o}, limit);
            for (int i = 0; i < (o == OR1 ? 7 : 5); i++) begin
                if (o == OR1) expect_ev(K_DC, b + 22 + i, {27'b0, or1_seq[i]}, limit);
                else          expect_ev(K_DC, b + 22 + i, {27'b0, two_seq[i]}, limit);
            end
            for (int w = 0; w < 2; w++) begin
                expect_ev(K_EI, b + (w == 1 ? 60 : 40), 32'd0, limit);
                for (int j = 0; j < 15; j++)
                    expect_ev(K_ER, b + (w == 1 ? 61 : 41) + j, 32768 / (15 - j), limit);
                if (w == 0) expect_ev(K_MR, b + 58, 32'd0, limit);
            end
            expect_ev(K_RP, b + 78, 32'd0, limit);
            expect_ev(K_EX, b + 80, 32'd0, limit);
            if (b + 80 <= limit) xrun[b + 80] = 1'b1;
        end
        expect_ev(K_DN, c + 1 + r * IT, {30'b0, THR}, limit);
        for (int t = c + 1; t <= c + r * IT && t <= limit; t++) run_exp[t] = 1'b1;
    endtask

    // ab/rs/sh/rw: cycle offsets after the start cycle for abort, 2-cycle reset, shift, stray run_write (-1 = none)
    task automatic do_run(input int r, input logic [1:0] m, input int ab, input int rs, input int sh, input int rw);
        int c, limit, len, it_exp;
        @(negedge clk);
        c = cyc;
        run_write = 1'b1;
        run_times = CNT_W'(r);
        mode_sel  = m;
        limit = ab >= 0 ? c + ab : rs >= 0 ? c + rs : c + r * IT + 10;
        push_run(c, r, m, limit);
        len = (ab >= 0 ? ab : rs >= 0 ? rs : r * IT) + 3;
        for (int d = 1; d <= len; d++) begin
            @(negedge clk);
            run_write      = d == rw;
            run_times      = CNT_W'($urandom);
            mode_sel       = 2'($urandom);
            abort          = d == ab;
            reset          = rs >= 0 && (d == rs || d == rs + 1);
            exchange_shift = d == sh;
        end
        @(negedge clk);
        {run_write, abort, reset, exchange_shift} = '0;
        it_exp = rs >= 0 ? 0 : ab >= 0 ? (ab - 1) / IT : r;
        if (r > 0) chk("iter_cnt", iter_cnt, it_exp);
        chk("end_running", running, 0);
        chk("end_opt_command", opt_command, THR);
        chk("end_distance_com", distance_com, DIST_NOP);
        chk("end_exp_run", exp_run, 0);
        if (rs >= 0) chk("reset_exp_recip", exp_recip, 0);
    endtask

    // monitor: every asserted strobe retires the next expected event; running and bank checked each cycle
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk);
            #1;
            if (random_run)     see_ev(K_RR, {30'b0, opt_command});
            if (done)           see_ev(K_DN, {30'b0, opt_command});
            if (metropolis_run) see_ev(K_MR, 32'd0);
            if (replica_run)    see_ev(K_RP, 32'd0);
            if (exchange_run)   see_ev(K_EX, 32'd0);
            if (exp_init)       see_ev(K_EI, 32'd0);
            if (exp_run)        see_ev(K_ER, {15'b0, exp_recip});
            if (distance_com != DIST_NOP) see_ev(K_DC, {27'b0, distance_com});
            chk("running", running, run_exp.exists(cyc));
            chk("exchange_bank", exchange_bank, model_bank);
            model_bank = reset ? 1'b0 : model_bank ^ (xrun.exists(cyc) || exchange_shift);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_iter_cnt", iter_cnt, 0);
        chk("rst_opt_command", opt_command, THR);
        chk("rst_random_run", random_run, 0);
        chk("rst_distance_com", distance_com, DIST_NOP);
        chk("rst_exchange_bank", exchange_bank, 0);
        chk("rst_exp_run", exp_run, 0);
        chk("rst_exp_recip", exp_recip, 0);
        mon_en = 1'b1;
        do_run(3, 2'b00, -1, -1, -1, 50);
        do_run(1, 2'b10, -1, -1, 81, -1);
        do_run(0, 2'b01, -1, -1, -1, -1);
        do_run(2, 2'b11, 152, -1, -1, 100);
        do_run(1, 2'b01, -1, -1, -1, -1);
        do_run(0, 2'b00, 1, -1, 2, -1);
        @(negedge clk);
        run_write = 1'b1;
        abort     = 1'b1;
        run_times = CNT_W'(5);
        @(negedge clk);
        {run_write, abort} = '0;
        repeat (3) @(negedge clk);
        chk("rw_with_abort_ignored", running, 0);
        do_run(2, 2'b00, -1, 147, -1, 10);
        for (int k = 0; k < 10; k++) begin
            int r, ab, rs, sh, rw;
            logic [1:0] m;
            r  = $urandom_range(0, 3);
            m  = 2'($urandom_range(0, 3));
            ab = -1;
            rs = -1;
            rw = -1;
            if (r > 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, r * IT);
            else if (r > 0 && $urandom_range(0, 3) == 0) rs = $urandom_range(1, r * IT);
            if (r > 0) rw = $urandom_range(1, ab > 0 ? ab : rs > 0 ? rs : r * IT);
            sh = $urandom_range(1, r * IT + 3);
            do_run(r, m, ab, rs, sh, rw);
        end
        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
